booth_mac_acc: RTL and testbench
================================

// Module: booth_mac_acc
// PURPOSE
//  Sequential accumulator placed directly downstream of the 4x4 signed Booth multiplier.
//  - Consumes a stream of signed 8-bit products over a valid/ready handshake.
//  - Sums N_TERMS products into a wider signed accumulator.
//  - Presents the dot-product result on a valid/ready output port, with a sticky overflow flag.
// PARAMETERS
//  PROD_W   8   width of signed product input (matches multiplier output)
//  ACC_W    16  width of signed accumulator/result; must be >= PROD_W
//  N_TERMS  4   products per accumulation; >= 1; counter width $clog2(N_TERMS+1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin new accumulation (honoured only in IDLE)
//  in_valid   in   1       prod is valid
//  in_ready   out  1       block accepts prod this cycle
//  prod       in   PROD_W  signed product from multiplier
//  out_valid  out  1       acc_out holds final sum
//  out_ready  in   1       consumer takes acc_out
//  acc_out    out  ACC_W   signed accumulated sum
//  ovf        out  1       sticky: signed overflow occurred during this accumulation
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, acc_out=0, count=0, ovf=0, in_ready=0, out_valid=0, busy=0.
//    Reset mid-operation aborts; partial sum discarded.
//  - FSM states:
//    IDLE  -> ACCUM on start; same edge clears acc_out, count and ovf.
//    ACCUM -> in_ready=1; each edge with in_valid&in_ready adds sign_ext(prod) to acc and increments count.
//             Accept with count==N_TERMS-1 -> DONE.
//    DONE  -> out_valid=1; acc_out/ovf held stable; in_ready=0.
//             On out_valid&out_ready -> IDLE. out_valid may stall indefinitely.
//  - start outside IDLE is ignored. start and in_valid in the same IDLE cycle: prod is not accepted.
//  - in_ready is a pure function of state (registered); it does not depend on in_valid.
//  - Latency: out_valid rises the cycle after the last product is accepted.
//    Minimum accumulation = 1 (start) + N_TERMS + 1 cycles.
//  - Arithmetic: two's-complement. prod is sign-extended to ACC_W+1 bits, then added.
//    Overflow = result outside [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any overflow sets ovf until the next start.
//  - acc_out retains its last value in IDLE until the next start clears it.
// CONFIGURATION
//  Macro BOOTH_MAC_SAT_EN:
//   - defined:     on overflow, acc clamps to the max positive or max negative value; ovf still set.
//                  Subsequent adds operate on the clamped value.
//   - not defined: acc wraps modulo 2^ACC_W; ovf set.
// STRUCTURE
//  - Shared package booth_pkg:
//      state encoding IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
//      default widths BOOTH_PROD_W=8, BOOTH_ACC_W=16.
//  - One sub-module, booth_sat_add:
//      combinational ACC_W + sign-extended PROD_W adder;
//      outputs sum and ovf, with saturation under BOOTH_MAC_SAT_EN.
//  - FSM, counter and handshake regs stay in booth_mac_acc.
// TESTING
//  1. Basic sum: start; prods 49,-8,64,-56 with in_valid held
//     -> out_valid 1 cycle after 4th accept, acc_out=49, ovf=0.
//  2. Backpressure/bubbles: in_valid toggled 1,0,0,1...; out_ready low 5 cycles
//     -> only valid cycles counted; acc_out stable while out_valid&!out_ready; IDLE after out_ready.
//  3. Overflow, ACC_W=8, N_TERMS=2: prods 64,64
//     -> SAT_EN: acc_out=127, ovf=1; no SAT_EN: acc_out=-128, ovf=1.
//  4. Negative overflow, ACC_W=8, N_TERMS=3: prods -56,-56,-56
//     -> SAT_EN: -128; no SAT_EN: 88; ovf=1 both builds.
//  5. Reset mid-op: rst after 2 accepts -> all outputs 0 next cycle.
//     New start + 4x prod=1 -> acc_out=4.
//  6. Ignored start: start pulsed in ACCUM and in DONE -> no effect on count/acc.
//     start with in_valid in IDLE -> prod not accepted.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and default widths for the Booth MAC accumulator
package booth_pkg;

    localparam int BOOTH_PROD_W = 8;
    localparam int BOOTH_ACC_W  = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/booth_sat_add.sv
// rtl/booth_sat_add.sv - combinational accumulator + sign-extended product adder with overflow detect
//
// Ports:
//   acc   in  ACC_W   current signed accumulator value
//   prod  in  PROD_W  signed product to add
//   sum   out ACC_W   next accumulator value (wrapped, or clamped with BOOTH_MAC_SAT_EN)
//   ovf   out 1       signed overflow of this add
// Macro BOOTH_MAC_SAT_EN: when defined the sum clamps to the signed range on overflow.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int PROD_W = BOOTH_PROD_W,
    parameter int ACC_W  = BOOTH_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] wide;

    // One guard bit: the result is out of range exactly when the top two bits differ.
    assign wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef BOOTH_MAC_SAT_EN
    // Guard bit holds the true sign, so it selects which rail to clamp to.
    always_comb begin
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            sum = wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_mac_acc.sv
// rtl/booth_mac_acc.sv - accumulates N_TERMS signed products into a wide sum with sticky overflow
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start                 begin an accumulation (honoured only in IDLE)
//   in_valid/in_ready     product handshake, prod is the signed product
//   out_valid/out_ready   result handshake, acc_out is the signed sum
//   ovf                   sticky signed overflow for the current accumulation
//   busy                  high whenever the FSM is not IDLE
// Macro BOOTH_MAC_SAT_EN: saturating accumulation instead of wrapping.
module booth_mac_acc
    import booth_pkg::*;
#(
    parameter int PROD_W  = BOOTH_PROD_W,
    parameter int ACC_W   = BOOTH_ACC_W,
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    booth_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc  (acc_q),
        .prod (prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (in_valid && in_ready_q) begin
                    acc_d   = add_sum;
                    ovf_d   = ovf_q | add_ovf;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state so they never
        // depend combinationally on the inputs.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mac_acc.sv
// tb/tb_booth_mac_acc.sv - scoreboard bench for booth_mac_acc (16-bit/4-term and 8-bit/3-term instances)
module tb_booth_mac_acc;

`ifdef BOOTH_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, ovf_a, busy_a;
    logic [7:0]  prod_a;
    logic [15:0] acc_out_a;
    logic        start_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b, busy_b;
    logic [7:0]  prod_b;
    logic [7:0]  acc_out_b;

    booth_mac_acc #(.PROD_W(8), .ACC_W(16), .N_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .prod(prod_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .acc_out(acc_out_a),
        .ovf(ovf_a), .busy(busy_a)
    );

    booth_mac_acc #(.PROD_W(8), .ACC_W(8), .N_TERMS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .prod(prod_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .acc_out(acc_out_b),
        .ovf(ovf_b), .busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    int stim[$];
    int exp_acc_q[$];
    int exp_ovf_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic st, input logic iv, input int p, input logic ordy);
        if (sel == 0) begin
            start_a = st; in_valid_a = iv; prod_a = 8'(p); out_ready_a = ordy;
        end else begin
            start_b = st; in_valid_b = iv; prod_b = 8'(p); out_ready_b = ordy;
        end
    endtask

    function automatic int g_acc(input int sel);
        return (sel == 0) ? int'($signed(acc_out_a)) : int'($signed(acc_out_b));
    endfunction
    function automatic int g_ovf(input int sel);
        return (sel == 0) ? int'(ovf_a) : int'(ovf_b);
    endfunction
    function automatic int g_rdy(input int sel);
        return (sel == 0) ? int'(in_ready_a) : int'(in_ready_b);
    endfunction
    function automatic int g_ov(input int sel);
        return (sel == 0) ? int'(out_valid_a) : int'(out_valid_b);
    endfunction
    function automatic int g_busy(input int sel);
        return (sel == 0) ? int'(busy_a) : int'(busy_b);
    endfunction

    // Reference model of one accumulation: integer sum, then wrap or clamp to w bits.
    task automatic push_expected(input int w);
        int acc, ov, mx, mn;
        acc = 0; ov = 0;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        foreach (stim[i]) begin
            acc = acc + stim[i];
            if (acc > mx || acc < mn) begin
                ov = 1;
                if (SAT) acc = (acc > mx) ? mx : mn;
                else if (acc > mx) acc = acc - (1 << w);
                else acc = acc + (1 << w);
            end
        end
        exp_acc_q.push_back(acc);
        exp_ovf_q.push_back(ov);
    endtask

    task automatic run_acc(input string nm, input int sel, input bit gap, input int stall, input bit poke);
        int n, idx, k, ea, eo, rdy;
        logic iv;
        n = stim.size();
        push_expected(sel == 0 ? 16 : 8);
        // start cycle; with poke, a product is offered alongside start and must be ignored
        drive(sel, 1'b1, poke, 99, 1'b0);
        step();
        drive(sel, 1'b0, 1'b0, 0, 1'b0);
        check_eq({nm, "_busy"}, g_busy(sel), 1);
        check_eq({nm, "_ovf_clr"}, g_ovf(sel), 0);
        idx = 0; k = 0;
        while (idx < n && k < 200) begin
            iv  = gap ? (k % 3 == 0) : 1'b1;
            rdy = g_rdy(sel);
            drive(sel, poke && !iv, iv, stim[idx], 1'b0);
            step();
            if (iv && rdy == 1) idx++;
            k++;
        end
        drive(sel, 1'b0, 1'b0, 0, 1'b0);
        if (idx < n) check_eq({nm, "_feed_timeout"}, idx, n);
        check_eq({nm, "_lat"}, g_ov(sel), 1);
        check_eq({nm, "_rdy_done"}, g_rdy(sel), 0);
        ea = exp_acc_q.pop_front();
        eo = exp_ovf_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            check_eq({nm, "_stall_acc"}, g_acc(sel), ea);
            check_eq({nm, "_stall_ov"}, g_ov(sel), 1);
            drive(sel, poke, 1'b0, 0, 1'b0);
            step();
        end
        drive(sel, 1'b0, 1'b0, 0, 1'b1);
        check_eq({nm, "_acc"}, g_acc(sel), ea);
        check_eq({nm, "_ovf"}, g_ovf(sel), eo);
        step();
        drive(sel, 1'b0, 1'b0, 0, 1'b0);
        check_eq({nm, "_ov_drop"}, g_ov(sel), 0);
        check_eq({nm, "_idle"}, g_busy(sel), 0);
        check_eq({nm, "_hold"}, g_acc(sel), ea);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 1'b0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check_eq("rst_acc", g_acc(0), 0);
        check_eq("rst_rdy", g_rdy(0), 0);
        check_eq("rst_ov", g_ov(0), 0);
        check_eq("rst_busy", g_busy(0), 0);
        check_eq("rst_ovf_b", g_ovf(1), 0);

        stim = '{49, -8, 64, -56};
        run_acc("basic", 0, 1'b0, 0, 1'b0);

        stim = '{10, 20, -30, 100};
        run_acc("bubble", 0, 1'b1, 5, 1'b0);

        stim = '{64, 64, 0};
        run_acc("pos_ovf", 1, 1'b0, 1, 1'b0);

        stim = '{-56, -56, -56};
        run_acc("neg_ovf", 1, 1'b0, 0, 1'b0);

        // Reset after two accepted products aborts the accumulation.
        drive(0, 1'b1, 1'b0, 0, 1'b0);
        step();
        drive(0, 1'b0, 1'b1, 5, 1'b0);
        step();
        step();
        drive(0, 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_acc", g_acc(0), 0);
        check_eq("mid_rst_rdy", g_rdy(0), 0);
        check_eq("mid_rst_ov", g_ov(0), 0);
        check_eq("mid_rst_busy", g_busy(0), 0);
        check_eq("mid_rst_ovf", g_ovf(0), 0);
        stim = '{1, 1, 1, 1};
        run_acc("after_rst", 0, 1'b0, 0, 1'b0);

        stim = '{3, 4, 5, 6};
        run_acc("ign_start", 0, 1'b1, 3, 1'b1);

        stim = '{-128, -128, -128};
        run_acc("min_b", 1, 1'b1, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
